// File: rtl/timer_pkg.sv
// timer_pkg: channel state type and default widths shared by timer_multi and timer_channel
package timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} ch_state_e;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_PRESCALE_W = 16;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one compare channel (FSM, counter, shadow compare, sticky pending); in: clk rst tick start stop auto_reload int_en irq_clear cmp_value, out: done irq_pending counter
module timer_channel import timer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic             int_en,
  input  logic             irq_clear,
  input  logic [WIDTH-1:0] cmp_value,
  output logic             done,
  output logic             irq_pending,
  output logic [WIDTH-1:0] counter
);
  ch_state_e state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic done_q, done_d, pend_q, pend_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shadow_d = shadow_q;
    done_d = 1'b0;
    pend_d = pend_q & ~irq_clear;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      cnt_d = '0;
      shadow_d = cmp_value;
      state_d = RUN;
    end else if (state_q == RUN && tick) begin
      if (cnt_q == shadow_q) begin
        done_d = 1'b1;
        pend_d = pend_d | int_en;
        cnt_d = auto_reload ? '0 : cnt_q;
        state_d = auto_reload ? RUN : DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shadow_q <= '0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      done_q <= done_d;
      pend_q <= pend_d;
    end
  end
  assign done = done_q;
  assign irq_pending = pend_q;
  assign counter = cnt_q;
endmodule

// File: rtl/timer_multi.sv
// timer_multi: NUM_CH compare channels sharing one prescaler; in: clk rst enable prescale cmp_value start stop auto_reload int_en irq_clear, out: done irq_pending irq counter
module timer_multi import timer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_CH = 4,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PRESCALE_W-1:0]   prescale,
  input  logic [NUM_CH*WIDTH-1:0] cmp_value,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       auto_reload,
  input  logic [NUM_CH-1:0]       int_en,
  input  logic [NUM_CH-1:0]       irq_clear,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       irq_pending,
  output logic                    irq,
  output logic [NUM_CH*WIDTH-1:0] counter
);
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic tick;
  always_comb begin
    tick = enable && presc_cnt_q >= prescale;
    presc_cnt_d = (!enable || tick) ? '0 : presc_cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) presc_cnt_q <= '0;
    else presc_cnt_q <= presc_cnt_d;
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .start(start[g]),
      .stop(stop[g]),
      .auto_reload(auto_reload[g]),
      .int_en(int_en[g]),
      .irq_clear(irq_clear[g]),
      .cmp_value(cmp_value[g*WIDTH +: WIDTH]),
      .done(done[g]),
      .irq_pending(irq_pending[g]),
      .counter(counter[g*WIDTH +: WIDTH])
    );
  end
  assign irq = |irq_pending;
endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: directed self-checking bench for timer_multi with two 8-bit channels
module tb_timer_multi;
  logic clk = 1'b0;
  logic rst, enable, irq;
  logic [15:0] prescale;
  logic [15:0] cmp_value, counter;
  logic [1:0] start, stop, auto_reload, int_en, irq_clear, done, irq_pending;
  int n_checks = 0;
  int n_fail = 0;
  timer_multi #(.WIDTH(8), .NUM_CH(2), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .cmp_value(cmp_value),
    .start(start), .stop(stop), .auto_reload(auto_reload), .int_en(int_en),
    .irq_clear(irq_clear), .done(done), .irq_pending(irq_pending), .irq(irq), .counter(counter)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; enable = 1; prescale = 0; cmp_value = 0;
    start = 0; stop = 0; auto_reload = 0; int_en = 0; irq_clear = 0;
    step(2);
    rst = 0;
    check("rst_counter", counter, 0);
    check("rst_done", done, 0);
    check("rst_pending", irq_pending, 0);
    check("rst_irq", irq, 0);
    cmp_value = {8'd9, 8'd3};
    start = 2'b01; step(1); start = 0;
    check("t1_cnt_start", counter[7:0], 0);
    step(3);
    check("t1_cnt3", counter[7:0], 3);
    check("t1_nodone", done, 0);
    step(1);
    check("t1_done", done, 2'b01);
    check("t1_cnt_match", counter[7:0], 3);
    step(1);
    check("t1_done_off", done, 0);
    check("t1_hold", counter[7:0], 3);
    check("t1_ch1_idle", counter[15:8], 0);
    check("t1_no_pend", irq_pending, 0);
    prescale = 2; cmp_value[7:0] = 8'd1; auto_reload = 2'b01; int_en = 2'b01;
    start = 2'b01; step(1); start = 0;
    step(4);
    check("t2_cnt1", counter[7:0], 1);
    check("t2_nodone", done, 0);
    step(1);
    check("t2_done1", done, 2'b01);
    check("t2_pend_set", irq_pending, 2'b01);
    check("t2_irq", irq, 1);
    check("t2_reload", counter[7:0], 0);
    irq_clear = 2'b01; step(1); irq_clear = 0;
    check("t2_pend_clr", irq_pending, 0);
    check("t2_irq_clr", irq, 0);
    step(4);
    check("t2_gap", done, 0);
    step(1);
    check("t2_done2", done, 2'b01);
    check("t2_pend_again", irq_pending, 2'b01);
    irq_clear = 2'b01; step(1); irq_clear = 0;
    check("t3_pre_clr", irq_pending, 0);
    step(4);
    irq_clear = 2'b01; step(1); irq_clear = 0;
    check("t3_done", done, 2'b01);
    check("t3_set_wins", irq_pending, 2'b01);
    irq_clear = 2'b01; step(1); irq_clear = 0;
    stop = 2'b01; step(1); stop = 0;
    int_en = 0; auto_reload = 0;
    prescale = 0; cmp_value[15:8] = 8'd5;
    start = 2'b10; step(1); start = 0;
    check("t4_cnt0", counter[15:8], 0);
    step(1);
    check("t4_cnt1", counter[15:8], 1);
    cmp_value[15:8] = 8'd2;
    step(3);
    check("t4_cnt4", counter[15:8], 4);
    check("t4_nodone", done, 0);
    step(1);
    check("t4_cnt5", counter[15:8], 5);
    step(1);
    check("t4_done_old", done, 2'b10);
    check("t4_hold5", counter[15:8], 5);
    start = 2'b10; step(1); start = 0;
    step(2);
    check("t4_cnt2", counter[15:8], 2);
    check("t4_nodone2", done, 0);
    step(1);
    check("t4_done_new", done, 2'b10);
    check("t4_hold2", counter[15:8], 2);
    cmp_value[7:0] = 8'd50;
    start = 2'b01; step(1); start = 0;
    step(3);
    check("t5_cnt3", counter[7:0], 3);
    start = 2'b01; stop = 2'b01; step(1); start = 0; stop = 0;
    check("t5_stop_wins", counter[7:0], 3);
    step(3);
    check("t5_idle_hold", counter[7:0], 3);
    start = 2'b01; step(1); start = 0;
    step(2);
    check("t5_run2", counter[7:0], 2);
    enable = 0;
    step(10);
    check("t5_frozen", counter[7:0], 2);
    check("t5_frozen_done", done, 0);
    enable = 1;
    step(1);
    check("t5_resume", counter[7:0], 3);
    cmp_value[15:8] = 8'd1; auto_reload = 2'b10; int_en = 2'b11;
    start = 2'b10; step(1); start = 0;
    step(2);
    check("t6_pend", irq_pending, 2'b10);
    check("t6_irq", irq, 1);
    rst = 1; step(1); rst = 0;
    check("t6_rst_counter", counter, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_pending", irq_pending, 0);
    check("t6_rst_irq", irq, 0);
    step(3);
    check("t6_idle", counter, 0);
    start = 2'b01; step(1); start = 0;
    step(2);
    check("t6_restart", counter[7:0], 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
